// File: rtl/divu_12by4_seq_pkg.sv
// -----------------------------------------------------------------------------
// divu_12by4_seq_pkg
// Shared constants and types for the 12-by-4 sequential unsigned divider.
//   DIVIDEND_W / DIVISOR_W : operand widths
//   REM_W                  : partial remainder width (one guard bit over divisor)
//   CNT_W / LAST_STEP      : iteration counter width and terminal count
//   QUOT_DBZ               : quotient reported for a zero divisor
//   state_e                : controller states
// -----------------------------------------------------------------------------
package divu_12by4_seq_pkg;

    localparam int DIVIDEND_W = 12;
    localparam int DIVISOR_W  = 4;
    localparam int REM_W      = DIVISOR_W + 1;
    localparam int CNT_W      = $clog2(DIVIDEND_W);

    localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] QUOT_DBZ  = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/divu_12by4_seq_if.sv
// -----------------------------------------------------------------------------
// divu_12by4_seq_if
// Operand and result handshakes of the divider.
//   in_valid/in_ready   : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, div_by_zero)
// Modports:
//   master : the surrounding datapath (drives operands, consumes results)
//   slave  : the divider
// -----------------------------------------------------------------------------
interface divu_12by4_seq_if;
    import divu_12by4_seq_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/divu_restore_step.sv
// -----------------------------------------------------------------------------
// divu_restore_step
// One combinational restoring-division step.
//   rem_i     : current partial remainder (REM_W bits, always < divisor)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor
//   rem_o     : next partial remainder
//   q_bit_o   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module divu_restore_step
    import divu_12by4_seq_pkg::*;
(
    input  logic [REM_W-1:0]     rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [REM_W-1:0]     rem_o,
    output logic                 q_bit_o
);

    // The whole partial remainder is shifted so no bit is silently dropped;
    // the top bit is always zero because the remainder stays below the divisor.
    logic [REM_W:0] p;

    assign p       = {rem_i, bit_i};
    assign q_bit_o = (p >= (REM_W + 1)'(divisor_i));
    assign rem_o   = q_bit_o ? REM_W'(p - (REM_W + 1)'(divisor_i)) : REM_W'(p);

endmodule

// File: rtl/divu_12by4_seq.sv
// -----------------------------------------------------------------------------
// divu_12by4_seq
// Sequential unsigned restoring divider: 12-bit dividend / 4-bit divisor,
// one quotient bit per clock. Inverse of the 4-bit multiply-accumulate stage.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : operand/result handshakes (slave side of divu_12by4_seq_if)
// A zero divisor skips the iterations and reports an all-ones quotient,
// zero remainder and div_by_zero in the cycle after acceptance.
// -----------------------------------------------------------------------------
module divu_12by4_seq
    import divu_12by4_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    divu_12by4_seq_if.slave bus
);

    state_e                state_q,   state_d;
    logic [DIVIDEND_W-1:0] shift_q,   shift_d;   // dividend in, quotient out
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [REM_W-1:0]      rem_q,     rem_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  dbz_q,     dbz_d;

    logic [REM_W-1:0]      step_rem;
    logic                  step_q_bit;

    divu_restore_step u_step (
        .rem_i     (rem_q),
        .bit_i     (shift_q[DIVIDEND_W-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    // NOTE: every register, datapath included, is cleared by reset so an
    // aborted division leaves no stale quotient or remainder on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no
        // latch is inferred.
        state_d   = state_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (bus.in_valid) begin
                    divisor_d = bus.divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (bus.divisor == '0) begin
                        shift_d = QUOT_DBZ;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        shift_d = bus.dividend;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                // Dividend MSB leaves on the left as the quotient bit enters
                // on the right; after DIVIDEND_W steps only quotient remains.
                shift_d = {shift_q[DIVIDEND_W-2:0], step_q_bit};
                rem_d   = step_rem;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = shift_q;
    assign bus.remainder   = rem_q[DIVISOR_W-1:0];
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_12by4_seq.sv
// -----------------------------------------------------------------------------
// tb_divu_12by4_seq
// Directed and round-trip checks for divu_12by4_seq.
// -----------------------------------------------------------------------------
module tb_divu_12by4_seq;
    import divu_12by4_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    divu_12by4_seq_if bus ();

    divu_12by4_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands, wait for in_ready, complete the accept edge.
    task automatic send(input logic [11:0] dd, input logic [3:0] dv);
        int guard = 0;
        bus.dividend = dd;
        bus.divisor  = dv;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_at_accept", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        // Junk on the operand lines must not disturb the running division.
        bus.dividend = 12'hA5A;
        bus.divisor  = 4'h3;
    endtask

    // Count edges after the accept edge until out_valid; watch in_ready.
    task automatic wait_valid(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [11:0] dd, input logic [3:0] dv,
                          input int exp_q, input int exp_r, input int exp_dbz, input int exp_lat);
        int lat;
        bit busy_ok;
        bus.out_ready = 1'b1;
        send(dd, dv);
        wait_valid(lat, busy_ok);
        check({tag, "_latency"},   32'(lat), 32'(exp_lat));
        check({tag, "_busy"},      32'(busy_ok), 1);
        check({tag, "_quotient"},  32'(bus.quotient), 32'(exp_q));
        check({tag, "_remainder"}, 32'(bus.remainder), 32'(exp_r));
        check({tag, "_dbz"},       32'(bus.div_by_zero), 32'(exp_dbz));
        tick();
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        int lat;
        bit busy_ok;
        int a, b, c;

        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready",  32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_quotient",  32'(bus.quotient), 0);
        check("rst_remainder", 32'(bus.remainder), 0);
        check("rst_dbz",       32'(bus.div_by_zero), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: basic divide, 12-edge latency
        run_op("t1_100div7", 12'd100, 4'd7, 14, 2, 0, 12);

        // 2: extreme dividends
        run_op("t2_fffdiv1",  12'hFFF, 4'd1,  4095, 0, 0, 12);
        run_op("t2_fffdiv15", 12'hFFF, 4'd15, 273,  0, 0, 12);

        // 3: zero divisor, then a normal op
        run_op("t3_dbz",     12'd123, 4'd0, 4095, 0, 1, 0);
        run_op("t3_50div5",  12'd50,  4'd5, 10,   0, 0, 12);

        // 4: consumer stalls for 5 cycles
        bus.out_ready = 1'b0;
        send(12'd5, 4'd9);
        wait_valid(lat, busy_ok);
        check("t4_latency", 32'(lat), 12);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid",     32'(bus.out_valid), 1);
            check("t4_hold_quotient",  32'(bus.quotient), 0);
            check("t4_hold_remainder", 32'(bus.remainder), 5);
            check("t4_hold_in_ready",  32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("t4_valid_drop", 32'(bus.out_valid), 0);
        check("t4_ready_back", 32'(bus.in_ready), 1);

        // 5: reset during the 6th CALC step
        send(12'd1000, 4'd3);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("t5_rst_in_ready",  32'(bus.in_ready), 1);
        check("t5_rst_out_valid", 32'(bus.out_valid), 0);
        check("t5_rst_quotient",  32'(bus.quotient), 0);
        check("t5_rst_remainder", 32'(bus.remainder), 0);
        check("t5_rst_dbz",       32'(bus.div_by_zero), 0);
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("t5_no_stale_valid", 32'(bus.out_valid), 0);
        end
        run_op("t5_200div13", 12'd200, 4'd13, 15, 5, 0, 12);

        // 6: random round trip a*b+c with random output stalls
        for (int it = 0; it < 1000; it++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(1, 15);
            c = $urandom_range(0, b - 1);
            bus.out_ready = 1'b0;
            send(12'(a * b + c), 4'(b));
            wait_valid(lat, busy_ok);
            check("t6_latency",   32'(lat), 12);
            check("t6_quotient",  32'(bus.quotient), 32'(a));
            check("t6_remainder", 32'(bus.remainder), 32'(c));
            repeat ($urandom_range(0, 3)) tick();
            bus.out_ready = 1'b1;
            tick();
            check("t6_valid_drop", 32'(bus.out_valid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
